// File: rtl/spi_globals_pkg.sv
// Shared SPI stimulus definitions: slave count, default word length
// and the transfer state encoding.
package spi_globals_pkg;

  localparam int NO_OF_SLAVES = 3;
  localparam int CHAR_LENGTH  = 8;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    CS_HOLD,
    FINISH
  } spi_state_e;

endpackage

// File: rtl/spi_sclk_gen.sv
// Half-period divider and sclk toggler for one transfer, with strobes
// marking the leading, trailing and final sclk edge.
module spi_sclk_gen #(
  parameter int CHAR_LENGTH = 8,
  parameter int DELAY_WIDTH = 8
) (
  input  logic                 pclk,
  input  logic                 areset,
  input  logic                 load_i,
  input  logic                 cpol_i,
  input  logic                 en_i,
  input  logic [DELAY_WIDTH:0] div_i,
  output logic                 sclk_o,
  output logic                 leading_o,
  output logic                 trailing_o,
  output logic                 last_edge_o
);

  localparam int EW = $clog2(2 * CHAR_LENGTH);
  localparam logic [EW-1:0] LAST = EW'(2 * CHAR_LENGTH - 1);

  logic [DELAY_WIDTH:0] cnt_q;
  logic [EW-1:0]        ecnt_q;
  logic                 sclk_q;
  logic                 tick;

  assign tick        = en_i && (cnt_q == div_i - 1'b1);
  assign leading_o   = tick && !ecnt_q[0];
  assign trailing_o  = tick && ecnt_q[0];
  assign last_edge_o = tick && (ecnt_q == LAST);
  assign sclk_o      = sclk_q;

  always_ff @(posedge pclk) begin
    if (areset) begin
      cnt_q  <= '0;
      ecnt_q <= '0;
      sclk_q <= 1'b0;
    end else if (load_i) begin
      cnt_q  <= '0;
      ecnt_q <= '0;
      sclk_q <= cpol_i;
    end else if (tick) begin
      cnt_q  <= '0;
      ecnt_q <= ecnt_q + 1'b1;
      sclk_q <= ~sclk_q;
    end else if (en_i) begin
      cnt_q  <= cnt_q + 1'b1;
    end else begin
      cnt_q  <= '0;
      ecnt_q <= '0;
    end
  end

endmodule

// File: rtl/spi_assertion_stimulus_gen.sv
// SPI master-side stimulus generator: drives cs, sclk and both data
// lanes for one word per start, with programmable delays and mode.
module spi_assertion_stimulus_gen #(
  parameter int NO_OF_SLAVES = spi_globals_pkg::NO_OF_SLAVES,
  parameter int CHAR_LENGTH  = spi_globals_pkg::CHAR_LENGTH,
  parameter int DELAY_WIDTH  = 8,
  localparam int SW = (NO_OF_SLAVES > 1) ? $clog2(NO_OF_SLAVES) : 1
) (
  input  logic                    pclk,
  input  logic                    areset,
  input  logic                    start,
  input  logic [SW-1:0]           slave_sel,
  input  logic                    cpol,
  input  logic                    cpha,
  input  logic                    msb_first,
  input  logic [DELAY_WIDTH-1:0]  baud_div,
  input  logic [DELAY_WIDTH-1:0]  ct2_delay,
  input  logic [DELAY_WIDTH-1:0]  t2c_delay,
  input  logic [CHAR_LENGTH-1:0]  mosi_data,
  input  logic [CHAR_LENGTH-1:0]  miso_data,
  output logic                    sclk,
  output logic [NO_OF_SLAVES-1:0] cs,
  output logic                    mosi0,
  output logic                    miso0,
  output logic                    busy,
  output logic                    done,
  output logic                    sel_err
);

  import spi_globals_pkg::*;

  localparam int DW = DELAY_WIDTH;
  localparam int CL = CHAR_LENGTH;
  localparam int IW = $clog2(CL + 1);
  localparam logic [SW:0] NS = (SW + 1)'(NO_OF_SLAVES);

  typedef logic [DW:0] dly_t;

  function automatic dly_t at_least_one(logic [DW-1:0] v);
    return (v == '0) ? dly_t'(1) : {1'b0, v};
  endfunction

  spi_state_e state_q, state_d;

  logic          cpha_q;
  logic          msb_q;
  logic          bad_q;
  logic [SW-1:0] sel_q;
  dly_t          div_q;
  dly_t          ct2_q;
  dly_t          t2c_q;
  dly_t          dly_q;
  logic [CL-1:0] mw_q;
  logic [CL-1:0] sw_q;
  logic [IW-1:0] idx_q;
  logic          mosi_q;
  logic          miso_q;

  logic          accept;
  logic          lead;
  logic          trail;
  logic          last;
  logic          adv;
  logic          cs_act;
  logic          nb_m;
  logic          nb_s;
  logic [CL-1:0] m_lsb, m_msb, s_lsb, s_msb;

  assign accept = (state_q == IDLE) && start;

  spi_sclk_gen #(
    .CHAR_LENGTH (CL),
    .DELAY_WIDTH (DW)
  ) u_sclk (
    .pclk        (pclk),
    .areset      (areset),
    .load_i      (accept),
    .cpol_i      (cpol),
    .en_i        (state_q == SHIFT),
    .div_i       (div_q),
    .sclk_o      (sclk),
    .leading_o   (lead),
    .trailing_o  (trail),
    .last_edge_o (last)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (start) state_d = CS_SETUP;
      CS_SETUP: if (dly_q == ct2_q - 1'b1) state_d = SHIFT;
      SHIFT: begin
        if (last) state_d = (t2c_q == '0) ? FINISH : CS_HOLD;
      end
      CS_HOLD:  if (dly_q == t2c_q - 1'b1) state_d = FINISH;
      FINISH:   state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (areset) begin
      state_q <= IDLE;
      dly_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q)
        dly_q <= '0;
      else if (state_q == CS_SETUP || state_q == CS_HOLD)
        dly_q <= dly_q + 1'b1;
    end
  end

  always_ff @(posedge pclk) begin
    if (areset) begin
      cpha_q <= 1'b0;
      msb_q  <= 1'b0;
      bad_q  <= 1'b0;
      sel_q  <= '0;
      div_q  <= '0;
      ct2_q  <= '0;
      t2c_q  <= '0;
      mw_q   <= '0;
      sw_q   <= '0;
    end else if (accept) begin
      cpha_q <= cpha;
      msb_q  <= msb_first;
      bad_q  <= {1'b0, slave_sel} >= NS;
      sel_q  <= slave_sel;
      div_q  <= at_least_one(baud_div);
      ct2_q  <= at_least_one(ct2_delay);
      t2c_q  <= {1'b0, t2c_delay};
      mw_q   <= mosi_data;
      sw_q   <= miso_data;
    end
  end

  // Bit picked by idx_q in the latched shift order.
  always_comb begin
    m_lsb = mw_q >> idx_q;
    m_msb = mw_q << idx_q;
    s_lsb = sw_q >> idx_q;
    s_msb = sw_q << idx_q;
    nb_m  = msb_q ? m_msb[CL-1] : m_lsb[0];
    nb_s  = msb_q ? s_msb[CL-1] : s_lsb[0];
  end

  // cpha=0 preloads bit 0 and the final trailing edge must not advance.
  assign adv = cpha_q ? lead : (trail && !last);

  always_ff @(posedge pclk) begin
    if (areset) begin
      idx_q  <= '0;
      mosi_q <= 1'b0;
      miso_q <= 1'b0;
    end else if (accept) begin
      idx_q  <= cpha ? IW'(0) : IW'(1);
      mosi_q <= !cpha && (msb_first ? mosi_data[CL-1] : mosi_data[0]);
      miso_q <= !cpha && (msb_first ? miso_data[CL-1] : miso_data[0]);
    end else if (state_d == FINISH) begin
      idx_q  <= '0;
      mosi_q <= 1'b0;
      miso_q <= 1'b0;
    end else if (adv) begin
      idx_q  <= idx_q + 1'b1;
      mosi_q <= nb_m;
      miso_q <= nb_s;
    end
  end

  assign cs_act = !bad_q && (state_q == CS_SETUP ||
                  state_q == SHIFT || state_q == CS_HOLD);

  always_comb begin
    cs = '1;
    for (int i = 0; i < NO_OF_SLAVES; i++) begin
      if (cs_act && sel_q == SW'(i)) cs[i] = 1'b0;
    end
  end

  assign mosi0   = mosi_q;
  assign miso0   = miso_q;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == FINISH);
  assign sel_err = done && bad_q;

endmodule

// File: tb/tb_spi_assertion_stimulus_gen.sv
// Scoreboard bench: each start pushes its expected transfer, a monitor
// measures cs/sclk/data and compares when done pulses.
module tb_spi_assertion_stimulus_gen;

  localparam int NS = 3;

  logic       pclk = 1'b0;
  logic       areset = 1'b1;
  logic       start = 1'b0;
  logic [1:0] slave_sel = '0;
  logic       cpol = 1'b0;
  logic       cpha = 1'b0;
  logic       msb_first = 1'b0;
  logic [7:0] baud_div = 8'd1;
  logic [7:0] ct2_delay = 8'd1;
  logic [7:0] t2c_delay = 8'd1;
  logic [7:0] mosi_data = '0;
  logic [7:0] miso_data = '0;
  logic       sclk;
  logic [2:0] cs;
  logic       mosi0, miso0, busy, done, sel_err;

  spi_assertion_stimulus_gen dut (
    .pclk      (pclk),
    .areset    (areset),
    .start     (start),
    .slave_sel (slave_sel),
    .cpol      (cpol),
    .cpha      (cpha),
    .msb_first (msb_first),
    .baud_div  (baud_div),
    .ct2_delay (ct2_delay),
    .t2c_delay (t2c_delay),
    .mosi_data (mosi_data),
    .miso_data (miso_data),
    .sclk      (sclk),
    .cs        (cs),
    .mosi0     (mosi0),
    .miso0     (miso0),
    .busy      (busy),
    .done      (done),
    .sel_err   (sel_err)
  );

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int         done_cyc;
    int         cs_low;
    logic [7:0] bm;
    logic [7:0] bs;
    logic       cpol;
    logic       cpha;
    logic       err;
    logic [1:0] sel;
  } exp_t;

  exp_t q[$];

  function automatic logic [7:0] order(logic [7:0] w, logic msb);
    logic [7:0] o;
    for (int k = 0; k < 8; k++) o[k] = msb ? w[7-k] : w[k];
    return o;
  endfunction

  function automatic exp_t mk(int n, logic cp, logic ch, logic msb,
                              logic [1:0] sel, logic [7:0] bd,
                              logic [7:0] c2, logic [7:0] t2,
                              logic [7:0] md, logic [7:0] sd);
    exp_t e;
    int bde, c2e, span;
    bde = (bd == 0) ? 1 : int'(bd);
    c2e = (c2 == 0) ? 1 : int'(c2);
    span = c2e + 16 * bde + int'(t2);
    e.done_cyc = n + span + 1;
    e.err      = (sel >= NS);
    e.cs_low   = e.err ? 0 : span;
    e.bm       = order(md, msb);
    e.bs       = order(sd, msb);
    e.cpol     = cp;
    e.cpha     = ch;
    e.sel      = sel;
    return e;
  endfunction

  task automatic drive(logic cp, logic ch, logic msb, logic [1:0] sel,
                       logic [7:0] bd, logic [7:0] c2, logic [7:0] t2,
                       logic [7:0] md, logic [7:0] sd);
    cpol = cp; cpha = ch; msb_first = msb; slave_sel = sel;
    baud_div = bd; ct2_delay = c2; t2c_delay = t2;
    mosi_data = md; miso_data = sd;
  endtask

  task automatic xfer(logic cp, logic ch, logic msb, logic [1:0] sel,
                      logic [7:0] bd, logic [7:0] c2, logic [7:0] t2,
                      logic [7:0] md, logic [7:0] sd, output int dc);
    exp_t e;
    @(negedge pclk);
    drive(cp, ch, msb, sel, bd, c2, t2, md, sd);
    start = 1'b1;
    e = mk(cyc, cp, ch, msb, sel, bd, c2, t2, md, sd);
    q.push_back(e);
    dc = e.done_cyc;
    @(negedge pclk);
    start = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 4000 && q.size() != 0; i++) @(negedge pclk);
    if (q.size() != 0) begin
      check("drain_timeout", q.size(), 0);
      q.delete();
    end
    @(negedge pclk);
  endtask

  // Data is taken from the cycle before the sampling edge.
  initial begin
    int csl, tog, ns, csw;
    logic [7:0] om, os;
    logic ps, pb, pm, pmi, pend;
    exp_t e;
    csl = 0; tog = 0; ns = 0; csw = 0; om = '0; os = '0;
    ps = 0; pb = 0; pm = 0; pmi = 0; pend = 0;
    forever begin
      @(negedge pclk);
      if (pend) check("idle_after_done", busy, 0);
      pend = 0;
      if (areset) begin
        csl = 0; tog = 0; ns = 0; csw = 0; om = '0; os = '0;
      end else begin
        if (pb && busy && q.size() > 0 && sclk !== ps) begin
          tog++;
          if (sclk == (q[0].cpol == q[0].cpha) && ns < 8) begin
            om[ns] = pm;
            os[ns] = pmi;
            ns++;
          end
        end
        if (cs !== 3'b111) begin
          csl++;
          if (q.size() == 0 || cs !== ~(3'b001 << q[0].sel)) csw++;
        end
        if (done) begin
          if (q.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e = q.pop_front();
            check("done_cycle", cyc, e.done_cyc);
            check("cs_low_cycles", csl, e.cs_low);
            check("cs_pattern", csw, 0);
            check("sclk_toggles", tog, 16);
            check("sclk_end_level", sclk, e.cpol);
            check("mosi_bits", om, e.bm);
            check("miso_bits", os, e.bs);
            check("sel_err", sel_err, e.err);
            check("finish_lanes", {mosi0, miso0}, 0);
          end
          csl = 0; tog = 0; ns = 0; csw = 0; om = '0; os = '0;
          pend = 1;
        end else if (sel_err) begin
          check("sel_err_without_done", 1, 0);
        end
      end
      ps = sclk; pb = busy; pm = mosi0; pmi = miso0;
    end
  end

  initial begin
    int   dc, n;
    exp_t e1, e2;
    repeat (3) @(negedge pclk);
    check("rst_cs", cs, 3'b111);
    check("rst_sclk", sclk, 0);
    check("rst_lanes", {mosi0, miso0}, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sel_err", sel_err, 0);
    areset = 1'b0;

    @(negedge pclk);
    areset = 1'b1; start = 1'b1;
    @(negedge pclk);
    areset = 1'b0; start = 1'b0;
    check("start_in_reset", busy, 0);
    @(negedge pclk);
    check("start_in_reset_b", busy, 0);

    // mode 0 lsb-first, with a start pulse while busy
    xfer(0, 0, 0, 2'd0, 8'd2, 8'd2, 8'd1, 8'hA5, 8'h5A, dc);
    repeat (10) @(negedge pclk);
    start = 1'b1; mosi_data = 8'hFF;
    @(negedge pclk);
    start = 1'b0;
    wait_drain();

    // mode 3 msb-first, with a start pulse during FINISH
    xfer(1, 1, 1, 2'd1, 8'd1, 8'd3, 8'd2, 8'h81, 8'h3C, dc);
    for (int i = 0; i < 200 && cyc < dc; i++) @(negedge pclk);
    start = 1'b1;
    @(negedge pclk);
    start = 1'b0;
    wait_drain();
    check("finish_start_ignored", busy, 0);

    // zero delays, mode 1, CS_HOLD skipped
    xfer(0, 1, 0, 2'd2, 8'd0, 8'd0, 8'd0, 8'hC3, 8'h96, dc);
    wait_drain();

    // out-of-range select, mode 2
    xfer(1, 0, 1, 2'd3, 8'd1, 8'd1, 8'd1, 8'h5A, 8'hF0, dc);
    wait_drain();

    // abort in the 10th SHIFT cycle
    @(negedge pclk);
    drive(1, 0, 0, 2'd0, 8'd1, 8'd2, 8'd1, 8'hFF, 8'hFF);
    start = 1'b1;
    n = cyc;
    @(negedge pclk);
    start = 1'b0;
    for (int i = 0; i < 100 && cyc < n + 12; i++) @(negedge pclk);
    areset = 1'b1;
    @(negedge pclk);
    check("abort_cs", cs, 3'b111);
    check("abort_sclk", sclk, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    areset = 1'b0;
    repeat (20) @(negedge pclk);
    xfer(0, 0, 1, 2'd1, 8'd3, 8'd2, 8'd2, 8'h6B, 8'hD4, dc);
    wait_drain();

    // start held: two back-to-back transfers, inputs changed mid-flight
    @(negedge pclk);
    drive(0, 0, 0, 2'd0, 8'd1, 8'd1, 8'd1, 8'hA5, 8'h3C);
    start = 1'b1;
    e1 = mk(cyc, 0, 0, 0, 2'd0, 8'd1, 8'd1, 8'd1, 8'hA5, 8'h3C);
    e2 = mk(e1.done_cyc + 1, 1, 1, 1, 2'd2, 8'd2, 8'd2, 8'd0,
            8'h96, 8'h69);
    q.push_back(e1);
    q.push_back(e2);
    repeat (5) @(negedge pclk);
    drive(1, 1, 1, 2'd2, 8'd2, 8'd2, 8'd0, 8'h96, 8'h69);
    for (int i = 0; i < 200 && cyc < e1.done_cyc + 3; i++)
      @(negedge pclk);
    drive(0, 1, 0, 2'd1, 8'd3, 8'd0, 8'd3, 8'h00, 8'hFF);
    start = 1'b0;
    wait_drain();
    repeat (3) @(negedge pclk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
